sr_rand_source: RTL
===================

// Module: sr_rand_source
// PURPOSE
//  Upstream random-bit source for the stochastic-rounding datapath in SRFPU.
//  An unrolled Galois LFSR produces one num_round_bits-wide word per cycle into a
//  small FIFO. The rounding stage pops one word per rounded result over a
//  valid/ready handshake. Software re-seeds through a load port for reproducible runs.
// PARAMETERS
//  num_round_bits  18            width of each random word delivered (1..32)
//  fifo_depth      4             FIFO entries (power of 2, >=2)
//  seed_default    32'h0000_0001 LFSR value after reset; also replaces a zero seed
// PORTS
//  clk          in   1               clock
//  reset        in   1               synchronous, active-high reset
//  gen_en       in   1               allow LFSR advance / FIFO push
//  seed_valid   in   1               load seed_data this cycle
//  seed_data    in   32              new LFSR state
//  rand_valid   out  1               FIFO head valid
//  rand_ready   in   1               consumer takes head this cycle
//  rand_data    out  num_round_bits  FIFO head word
//  fifo_count   out  $clog2(fifo_depth)+1  occupancy
// BEHAVIOUR
//  - Reset (clk edge with reset=1): LFSR<=seed_default, FIFO empty, rand_valid=0,
//    rand_data=0, fifo_count=0, FSM<=FILL. Reset overrides all other inputs.
//  - LFSR: 32-bit right-shift Galois, mask 32'h8020_0003 (x^32+x^22+x^2+x+1).
//    One step: s_next = (s>>1) ^ (s[0] ? mask : 0). Word bit i = s[0] before
//    step i. num_round_bits steps unrolled per cycle. LFSR advances only on a push.
//  - Push: gen_en && !seed_valid && (count<fifo_depth || pop). Pop: rand_valid && rand_ready.
//  - Push and pop in the same cycle at full: both occur, count unchanged.
//  - Push and pop in the same cycle at empty: pop cannot occur, so the push alone
//    happens. No bypass: a pushed word is visible one cycle later.
//  - Latency: word pushed at edge N is rand_data/rand_valid after edge N.
//    First valid word is at the 1st edge after the reset-release edge (gen_en=1).
//  - rand_data is registered from the FIFO head. It is held while rand_valid && !rand_ready.
//  - FSM:
//    - FILL: FIFO not full. Go to FULL when count reaches fifo_depth with no pop.
//    - FULL: pushes only with a concurrent pop. Go to FILL on a pop with gen_en=0.
//    - SEED: entered for one cycle on seed_valid from any state. Always returns to FILL.
//  - seed_valid: LFSR<=(seed_data==0 ? seed_default : seed_data). FIFO flushed, count<=0.
//    A same-cycle pop is discarded. rand_valid=0 next cycle. First fresh word
//    appears 2 edges after the seed edge.
//  - seed_valid held several cycles: reload each cycle. Nothing is pushed until it drops.
//  - gen_en=0: LFSR and pushes frozen. The FIFO may still drain to empty.
//  - Pointers wrap modulo fifo_depth. fifo_count never exceeds fifo_depth.
// CONFIGURATION
//  SR_RAND_STATS_EN defined:
//    - Adds out [31:0] words_out: pop count.
//    - Adds out [31:0] starve_cycles: cycles with rand_ready && !rand_valid.
//    - Both saturate at 32'hFFFF_FFFF and clear on reset or seed_valid.
//  SR_RAND_STATS_EN undefined: the ports and counters are absent. Core behaviour is identical.
// TESTING
//  - reset, gen_en=1, rand_ready=0, defaults -> after 1 edge rand_valid=1,
//    rand_data[3:0]=4'b1011. After 4 edges fifo_count=4, FULL, rand_data unchanged.
//  - Fill to 4, then rand_ready=1 for 10 cycles -> 10 distinct words, fifo_count stays 4,
//    word sequence equals the software LFSR model from seed 1.
//  - seed_valid=1, seed_data=0 while FIFO has 3 entries -> next cycle rand_valid=0,
//    fifo_count=0. Output sequence restarts identical to post-reset sequence.
//  - seed_data=32'hDEAD_BEEF loaded twice (separate runs) -> identical 8-word sequences.
//  - gen_en=0 with 2 entries, rand_ready=1 -> 2 pops, then rand_valid=0, LFSR unchanged.
//    Re-enable -> next word matches model continuation.
//  - With SR_RAND_STATS_EN: empty FIFO, gen_en=0, rand_ready=1 for 5 cycles ->
//    starve_cycles=5, words_out=0.
//  - Reset asserted mid-drain -> all outputs reset next edge.

Source files
------------

// File: rtl/sr_rand_source.sv
// ---------------------------------------------------------------------------
// sr_rand_source : LFSR random-word source with FIFO for stochastic rounding.
// Optional pop/starve statistics: define SR_RAND_STATS_EN.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sr_rand_source #(
  parameter int          num_round_bits = 18,
  parameter int          fifo_depth     = 4,
  parameter logic [31:0] seed_default   = 32'h0000_0001
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             gen_en,
  input  logic                             seed_valid,
  input  logic [31:0]                      seed_data,
  output logic                             rand_valid,
  input  logic                             rand_ready,
  output logic [num_round_bits-1:0]        rand_data,
`ifdef SR_RAND_STATS_EN
  output logic [31:0]                      words_out,
  output logic [31:0]                      starve_cycles,
`endif
  output logic [$clog2(fifo_depth):0]      fifo_count
);

  localparam int          ptr_w     = $clog2(fifo_depth);
  localparam int          cnt_w     = ptr_w + 1;
  localparam logic [31:0] lfsr_mask = 32'h8020_0003;

  typedef enum logic [1:0] {FILL = 2'd0, FULL = 2'd1, SEED = 2'd2} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               lfsr_q, lfsr_adv;
  logic [num_round_bits-1:0] word;
  logic [num_round_bits-1:0] mem [fifo_depth];
  logic [ptr_w-1:0]          rd_ptr, wr_ptr, rd_next;
  logic [cnt_w-1:0]          count_q, count_next, remaining;
  logic [num_round_bits-1:0] head_next;
  logic                      push, pop;

  // Unrolled Galois steps: word bit i is the LFSR output bit before step i.
  always_comb begin
    logic [31:0] s;
    s    = lfsr_q;
    word = '0;
    for (int i = 0; i < num_round_bits; i++) begin
      word[i] = s[0];
      s       = (s >> 1) ^ (s[0] ? lfsr_mask : 32'h0);
    end
    lfsr_adv = s;
  end

  assign rand_valid = (count_q != '0);
  assign fifo_count = count_q;
  assign pop        = rand_valid && rand_ready;
  // The cycle following a seed load is spent in SEED, so no word is generated then.
  assign push       = gen_en && !seed_valid && (state_q != SEED) &&
                      ((count_q < cnt_w'(fifo_depth)) || pop);

  always_comb begin
    count_next = count_q;
    if (seed_valid)
      count_next = '0;
    else if (push && !pop)
      count_next = count_q + 1'b1;
    else if (pop && !push)
      count_next = count_q - 1'b1;
  end

  assign rd_next   = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign remaining = pop ? count_q - 1'b1 : count_q;
  assign head_next = (remaining != '0) ? mem[rd_next] : word;

  always_comb begin
    state_d = state_q;
    if (seed_valid) begin
      state_d = SEED;
    end else begin
      case (state_q)
        FILL:    if (count_next == cnt_w'(fifo_depth)) state_d = FULL;
        FULL:    if (pop && !gen_en) state_d = FILL;
        SEED:    state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      lfsr_q    <= seed_default;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      rand_data <= '0;
    end else if (seed_valid) begin
      state_q <= state_d;
      lfsr_q  <= (seed_data == 32'h0) ? seed_default : seed_data;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        lfsr_q <= lfsr_adv;
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr  <= rd_next;
      count_q <= count_next;
      if (count_next != '0) rand_data <= head_next;
    end
  end

`ifdef SR_RAND_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || seed_valid) begin
      words_out     <= '0;
      starve_cycles <= '0;
    end else begin
      if (pop && (words_out != 32'hFFFF_FFFF))
        words_out <= words_out + 1'b1;
      if (rand_ready && !rand_valid && (starve_cycles != 32'hFFFF_FFFF))
        starve_cycles <= starve_cycles + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire
